// File: rtl/bin_pkg.sv
// Shared constants and types for the skin binarisation threshold controller.
package bin_pkg;

  localparam logic [2:0] CFG_ADDR_CB_MIN = 3'd0;
  localparam logic [2:0] CFG_ADDR_CB_MAX = 3'd1;
  localparam logic [2:0] CFG_ADDR_CR_MIN = 3'd2;
  localparam logic [2:0] CFG_ADDR_CR_MAX = 3'd3;
  localparam logic [2:0] CFG_ADDR_COMMIT = 3'd4;

  localparam logic [7:0] CB_MIN_DEF = 8'd105;
  localparam logic [7:0] CB_MAX_DEF = 8'd135;
  localparam logic [7:0] CR_MIN_DEF = 8'd125;
  localparam logic [7:0] CR_MAX_DEF = 8'd165;

  localparam logic [7:0] BIN_SKIN = 8'd255;

  typedef enum logic {StWaitSof, StActive} bin_state_e;

  // A threshold window is usable only if it is non-empty.
  function automatic logic thr_window_ok(input logic [7:0] lo, input logic [7:0] hi);
    return lo < hi;
  endfunction

endpackage

// File: rtl/bin_thresh_ctrl_sof_detect.sv
// Polarity-normalised vsync register and leading-edge (start-of-frame) detect.
module bin_thresh_ctrl_sof_detect #(
  parameter bit VS_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic sof
);

  logic vs;
  logic vs_d, vs_q;

  assign vs   = ~(vsync_in ^ VS_ACTIVE);
  assign vs_d = vs;
  assign sof  = vs && !vs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
    end
  end

endmodule

// File: rtl/bin_thresh_ctrl.sv
// Double-buffered Cb/Cr threshold registers committed at frame start, plus a
// per-frame skin pixel counter published once per frame.
module bin_thresh_ctrl
  import bin_pkg::*;
#(
  parameter logic [7:0]  CB_MIN_RST = CB_MIN_DEF,
  parameter logic [7:0]  CB_MAX_RST = CB_MAX_DEF,
  parameter logic [7:0]  CR_MIN_RST = CR_MIN_DEF,
  parameter logic [7:0]  CR_MAX_RST = CR_MAX_DEF,
  parameter int unsigned CNT_W      = 22,
  parameter bit          VS_ACTIVE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic [7:0]       cb_min,
  output logic [7:0]       cb_max,
  output logic [7:0]       cr_min,
  output logic [7:0]       cr_max,
  input  logic [7:0]       bin_in,
  input  logic             de_in,
  input  logic             vsync_in,
  output logic [CNT_W-1:0] skin_count,
  output logic             frame_done,
  output logic             cfg_err
);

  // Index order: 0=cb_min 1=cb_max 2=cr_min 3=cr_max, matching cfg_addr.
  localparam logic [3:0][7:0] THR_RST = {CR_MAX_RST, CR_MIN_RST, CB_MAX_RST, CB_MIN_RST};

  logic sof;
  logic hit;
  logic [CNT_W-1:0] cnt_inc;

  logic [3:0][7:0]  shad_d, shad_q;
  logic [3:0][7:0]  act_d, act_q;
  logic             pending_d, pending_q;
  logic             err_d, err_q;
  logic             done_d, done_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] skin_d, skin_q;
  bin_state_e       state_d, state_q;

  bin_thresh_ctrl_sof_detect #(
    .VS_ACTIVE(VS_ACTIVE)
  ) u_sof_detect (
    .clk     (clk),
    .rst     (rst),
    .vsync_in(vsync_in),
    .sof     (sof)
  );

  assign hit     = de_in && (bin_in == BIN_SKIN);
  assign cnt_inc = (hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    shad_d    = shad_q;
    act_d     = act_q;
    pending_d = pending_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    skin_d    = skin_q;
    state_d   = state_q;

    unique case (state_q)
      StWaitSof: begin
        if (sof) begin
          state_d = StActive;
          cnt_d   = '0;
        end
      end
      StActive: begin
        if (sof) begin
          // The sof-cycle pixel still belongs to the frame being closed.
          skin_d = cnt_inc;
          done_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StWaitSof;
    endcase

    if (sof && pending_q) begin
      pending_d = 1'b0;
      if (thr_window_ok(shad_q[0], shad_q[1]) && thr_window_ok(shad_q[2], shad_q[3])) begin
        act_d = shad_q;
      end else begin
        err_d = 1'b1;
      end
    end

    // Handshake only possible with no commit pending, so it never races the commit above.
    if (cfg_valid && !pending_q) begin
      unique case (cfg_addr)
        CFG_ADDR_CB_MIN, CFG_ADDR_CB_MAX, CFG_ADDR_CR_MIN, CFG_ADDR_CR_MAX: begin
          shad_d[cfg_addr[1:0]] = cfg_data;
        end
        CFG_ADDR_COMMIT: begin
          pending_d = 1'b1;
          err_d     = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shad_q    <= THR_RST;
      act_q     <= THR_RST;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      skin_q    <= '0;
      state_q   <= StWaitSof;
    end else begin
      shad_q    <= shad_d;
      act_q     <= act_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      skin_q    <= skin_d;
      state_q   <= state_d;
    end
  end

  assign cfg_ready  = !pending_q;
  assign cb_min     = act_q[0];
  assign cb_max     = act_q[1];
  assign cr_min     = act_q[2];
  assign cr_max     = act_q[3];
  assign skin_count = skin_q;
  assign frame_done = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_bin_thresh_ctrl.sv
// Directed bench for bin_thresh_ctrl: threshold commit timing, rejection,
// per-frame skin counts (22-bit and saturating 4-bit instances) and reset.
module tb_bin_thresh_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic [7:0]  bin_in = '0;
  logic        de_in = 1'b0;
  logic        vsync_in = 1'b0;

  logic        cfg_ready, cfg_err, frame_done;
  logic [7:0]  cb_min, cb_max, cr_min, cr_max;
  logic [21:0] skin_count;

  logic        cfg_ready4, cfg_err4, frame_done4;
  logic [7:0]  cb_min4, cb_max4, cr_min4, cr_max4;
  logic [3:0]  skin_count4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned c22;
    int unsigned c4;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bin_thresh_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cb_min    (cb_min),
    .cb_max    (cb_max),
    .cr_min    (cr_min),
    .cr_max    (cr_max),
    .bin_in    (bin_in),
    .de_in     (de_in),
    .vsync_in  (vsync_in),
    .skin_count(skin_count),
    .frame_done(frame_done),
    .cfg_err   (cfg_err)
  );

  bin_thresh_ctrl #(
    .CNT_W(4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready4),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cb_min    (cb_min4),
    .cb_max    (cb_max4),
    .cr_min    (cr_min4),
    .cr_max    (cr_max4),
    .bin_in    (bin_in),
    .de_in     (de_in),
    .vsync_in  (vsync_in),
    .skin_count(skin_count4),
    .frame_done(frame_done4),
    .cfg_err   (cfg_err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic de, input logic [7:0] b);
    de_in  = de;
    bin_in = b;
    tick();
  endtask

  task automatic pulse_vsync();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    int n;
    n         = 0;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    check("cfg_ready_before_write", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Scoreboard: every frame_done pulse must match the oldest expected frame.
  always @(posedge clk) begin
    #1;
    if (frame_done || frame_done4) begin
      check("frame_done_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_done_both", {frame_done, frame_done4}, 2'b11);
        check("skin_count", skin_count, e.c22);
        check("skin_count_sat4", skin_count4, e.c4);
      end
    end
  end

  initial begin
    // 1: reset and idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("rst_cb_min", cb_min, 105);
    check("rst_cb_max", cb_max, 135);
    check("rst_cr_min", cr_min, 125);
    check("rst_cr_max", cr_max, 165);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_skin_count", skin_count, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cfg_err", cfg_err, 0);

    // 2: commit cb window, applied exactly one cycle after the vsync edge
    cfg_write(3'd0, 8'd90);
    cfg_write(3'd1, 8'd140);
    cfg_write(3'd4, 8'd0);
    check("pending_ready_low", cfg_ready, 0);
    repeat (1000) tick();
    vsync_in = 1'b1;
    check("pre_sof_cb_min", cb_min, 105);
    tick();
    check("commit_cb_min", cb_min, 90);
    check("commit_cb_max", cb_max, 140);
    check("commit_cr_min_kept", cr_min, 125);
    check("commit_ready_back", cfg_ready, 1);
    check("first_frame_no_done", frame_done, 0);
    vsync_in = 1'b0;
    tick();

    // 3: rejected cr window, then a valid commit clears the error
    cfg_write(3'd2, 8'd170);
    cfg_write(3'd3, 8'd160);
    cfg_write(3'd4, 8'd0);
    exp_q.push_back('{c22: 0, c4: 0});
    pulse_vsync();
    check("reject_cr_min", cr_min, 125);
    check("reject_cr_max", cr_max, 165);
    check("reject_cb_min", cb_min, 90);
    check("reject_err", cfg_err, 1);
    cfg_write(3'd2, 8'd100);
    cfg_write(3'd3, 8'd200);
    cfg_write(3'd4, 8'd0);
    check("commit_clears_err", cfg_err, 0);
    exp_q.push_back('{c22: 0, c4: 0});
    pulse_vsync();
    check("accept_cr_min", cr_min, 100);
    check("accept_cr_max", cr_max, 200);
    check("accept_err", cfg_err, 0);

    // 4: 640 de cycles, 37 skin, 5 with 128, plus skin values with de low
    for (int i = 0; i < 640; i++) begin
      if (i >= 100 && i < 137) pix(1'b1, 8'd255);
      else if (i >= 200 && i < 205) pix(1'b1, 8'd128);
      else pix(1'b1, 8'd0);
    end
    repeat (10) pix(1'b0, 8'd255);
    pix(1'b0, 8'd0);
    exp_q.push_back('{c22: 37, c4: 15});
    pulse_vsync();

    // 5: 20 skin pixels, the last one in the sof cycle itself; then an empty frame
    repeat (19) pix(1'b1, 8'd255);
    exp_q.push_back('{c22: 20, c4: 15});
    de_in    = 1'b1;
    bin_in   = 8'd255;
    vsync_in = 1'b1;
    tick();
    de_in    = 1'b0;
    bin_in   = 8'd0;
    vsync_in = 1'b0;
    repeat (5) tick();
    exp_q.push_back('{c22: 0, c4: 0});
    pulse_vsync();

    // 6: reset mid-frame with a commit pending
    cfg_write(3'd0, 8'd50);
    cfg_write(3'd4, 8'd0);
    check("t6_pending", cfg_ready, 0);
    repeat (5) pix(1'b1, 8'd255);
    pix(1'b0, 8'd0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("t6_cb_min_rst", cb_min, 105);
    check("t6_cr_max_rst", cr_max, 165);
    check("t6_ready", cfg_ready, 1);
    check("t6_skin_count", skin_count, 0);
    pulse_vsync();
    check("t6_no_commit", cb_min, 105);
    check("t6_no_done", frame_done, 0);
    repeat (7) pix(1'b1, 8'd255);
    pix(1'b0, 8'd0);
    exp_q.push_back('{c22: 7, c4: 7});
    pulse_vsync();
    check("t6_cb_min_final", cb_min, 105);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
